// File: rtl/scmp_bus_ctrl.sv
// scmp_bus_ctrl: SC/MP external bus-cycle sequencer with wait states, hold_n stretching
// and the upper address bits multiplexed onto D during the address strobe.
module scmp_bus_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int PIN_ADDR_W = 12,
    parameter int DATA_W     = 8,
    parameter int MIN_WAIT   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bus_en,
    input  logic                  hold_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [3:0]            req_flags,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  busy,
    output logic [PIN_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     D_i,
    output logic [DATA_W-1:0]     D_o,
    output logic                  D_oe,
    output logic                  ADS_n,
    output logic                  RD_n,
    output logic                  WR_n
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_STROBE, S_DONE} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   a_q;
    logic [DATA_W-1:0]   wd_q;
    logic [DATA_W-1:0]   ads_d;
    logic [3:0]          fl_q;
    logic [3:0]          cnt;
    logic                we_q;
    logic                xfer;
    logic                strobe_end;

    assign req_ready  = (state == S_IDLE) && bus_en && rst_n;
    assign xfer       = req_valid && req_ready;
    // hold_n only matters once the programmed minimum wait has expired
    assign strobe_end = (state == S_STROBE) && (cnt == '0) && hold_n;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = xfer ? S_ADDR : S_IDLE;
            S_ADDR:   state_nx = S_STROBE;
            S_STROBE: state_nx = strobe_end ? S_DONE : S_STROBE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_q       <= '0;
            wd_q      <= '0;
            fl_q      <= '0;
            we_q      <= 1'b0;
            cnt       <= '0;
            rsp_rdata <= '0;
        end else begin
            state <= state_nx;
            if (xfer) begin
                a_q  <= req_addr;
                wd_q <= req_wdata;
                fl_q <= req_flags;
                we_q <= req_we;
            end
            if (state == S_ADDR)
                cnt <= 4'(MIN_WAIT);
            else if (state == S_STROBE && cnt != '0)
                cnt <= cnt - 4'd1;
            if (strobe_end && !we_q)
                rsp_rdata <= D_i;
        end
    end

    // flags occupy the top nibble, high address bits the LSBs
    assign ads_d     = {fl_q, {(DATA_W-4){1'b0}}} | DATA_W'(a_q >> PIN_ADDR_W);
    assign busy      = state != S_IDLE;
    assign rsp_valid = state == S_DONE;
    assign addr      = a_q[PIN_ADDR_W-1:0];
    assign ADS_n     = state != S_ADDR;
    assign RD_n      = !(state == S_STROBE && !we_q);
    assign WR_n      = !(state == S_STROBE && we_q);
    assign D_oe      = (state == S_ADDR) || (we_q && (state == S_STROBE || state == S_DONE));
    assign D_o       = (state == S_ADDR) ? ads_d : (D_oe ? wd_q : '0);
endmodule

// File: tb/tb_scmp_bus_ctrl.sv
// tb_scmp_bus_ctrl: checks two sequencers (MIN_WAIT 0 and 2) driven by shared stimulus
// against a cycle-level behavioural model, plus literal expectations for directed cases.
module tb_scmp_bus_ctrl;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        bus_en = 1, hold_n = 1, req_valid = 0, req_we = 0;
    logic [15:0] req_addr = 0;
    logic [7:0]  req_wdata = 0, d_i = 0;
    logic [3:0]  req_flags = 0;

    wire [1:0]  o_ready, o_rsp, o_busy, o_doe, o_ads, o_rd, o_wr;
    wire [11:0] o_addr [2];
    wire [7:0]  o_do [2];
    wire [7:0]  o_rdata [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        scmp_bus_ctrl #(.MIN_WAIT(2*g)) dut (
            .clk(clk), .rst_n(rst_n), .bus_en(bus_en), .hold_n(hold_n),
            .req_valid(req_valid), .req_ready(o_ready[g]), .req_we(req_we),
            .req_addr(req_addr), .req_wdata(req_wdata), .req_flags(req_flags),
            .rsp_valid(o_rsp[g]), .rsp_rdata(o_rdata[g]), .busy(o_busy[g]),
            .addr(o_addr[g]), .D_i(d_i), .D_o(o_do[g]), .D_oe(o_doe[g]),
            .ADS_n(o_ads[g]), .RD_n(o_rd[g]), .WR_n(o_wr[g])
        );
    end

    int n_cmp = 0, n_bad = 0, cyc = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc %0d: got %0h want %0h", nm, i, cyc, act, exp);
        end
    endtask

    // Model: m_c counts cycles since accept (1 = address cycle, 2.. = strobe);
    // m_end is the index of the completion cycle once the strobe has been released.
    bit        m_busy [2];
    bit        m_we [2];
    int        m_c [2], m_end [2], acc [2];
    bit [15:0] m_a [2];
    bit [7:0]  m_wd [2], m_rd [2];
    bit [3:0]  m_fl [2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_busy[i] = 0; m_a[i] = 0; m_rd[i] = 0; m_c[i] = 0; m_end[i] = 0;
            end else if (!m_busy[i]) begin
                if (req_valid && bus_en) begin
                    m_busy[i] = 1; m_c[i] = 1; m_end[i] = 0; acc[i] = cyc;
                    m_a[i] = req_addr; m_we[i] = req_we; m_wd[i] = req_wdata; m_fl[i] = req_flags;
                end
            end else if (m_c[i] == m_end[i]) begin
                m_busy[i] = 0;
            end else begin
                if (m_c[i] >= 2 && m_c[i] - 2 >= 2*i && hold_n) begin
                    m_end[i] = m_c[i] + 1;
                    if (!m_we[i]) m_rd[i] = d_i;
                end
                m_c[i]++;
            end
        end
        if (rst_n) cyc++;
    end

    int         ads_cnt [2], rd_cnt [2], wr_cnt [2], w77 [2], rsp_cnt [2], rsp_cyc [2], gap [2];
    logic [11:0] ads_addr [2];
    logic [7:0]  ads_do [2], rsp_val [2];

    always @(negedge clk) begin
        bit ap, sp, dp, oe;
        for (int i = 0; i < 2; i++) begin
            ap = m_busy[i] && m_c[i] == 1;
            sp = m_busy[i] && m_c[i] >= 2 && m_end[i] == 0;
            dp = m_busy[i] && m_end[i] != 0 && m_c[i] == m_end[i];
            oe = ap || (m_we[i] && (sp || dp));
            chk("req_ready", i, o_ready[i], !m_busy[i] && bus_en && rst_n);
            chk("busy", i, o_busy[i], m_busy[i]);
            chk("ADS_n", i, o_ads[i], !ap);
            chk("RD_n", i, o_rd[i], !(sp && !m_we[i]));
            chk("WR_n", i, o_wr[i], !(sp && m_we[i]));
            chk("D_oe", i, o_doe[i], oe);
            chk("rsp_valid", i, o_rsp[i], dp);
            chk("rsp_rdata", i, o_rdata[i], m_rd[i]);
            chk("addr", i, o_addr[i], m_a[i][11:0]);
            if (oe) chk("D_o", i, o_do[i], ap ? {m_fl[i], m_a[i][15:12]} : m_wd[i]);
            chk("strobe_overlap", i, int'(!o_ads[i]) + int'(!o_rd[i]) + int'(!o_wr[i]) > 1, 0);
            chk("rsp_with_ready", i, o_rsp[i] && o_ready[i], 0);
            if (!o_ads[i]) begin ads_cnt[i]++; ads_addr[i] = o_addr[i]; ads_do[i] = o_do[i]; end
            if (!o_rd[i]) rd_cnt[i]++;
            if (!o_wr[i]) wr_cnt[i]++;
            if (o_doe[i] && o_ads[i] && o_do[i] == 8'h77) w77[i]++;
            if (o_ready[i] && req_valid && rsp_cyc[i] >= 0) gap[i] = cyc - rsp_cyc[i];
            if (o_rsp[i]) begin rsp_cnt[i]++; rsp_cyc[i] = cyc; rsp_val[i] = o_rdata[i]; end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        for (int i = 0; i < 2; i++) begin
            ads_cnt[i] = 0; rd_cnt[i] = 0; wr_cnt[i] = 0; w77[i] = 0;
            rsp_cnt[i] = 0; rsp_cyc[i] = -1; gap[i] = -1;
        end
    endtask

    task automatic issue(input logic we, input logic [15:0] a, input logic [7:0] wd, input logic [3:0] fl);
        req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_flags = fl;
        step;
        req_valid = 0;
    endtask

    task automatic wait_idle;
        int k = 0;
        while (o_busy != 2'b00 && k < 200) begin step; k++; end
        chk("idle_timeout", 0, o_busy, 0);
    endtask

    int c0;

    initial begin
        clr;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_strobes", i, {o_ads[i], o_rd[i], o_wr[i]}, 3'b111);
            chk("rst_doe", i, o_doe[i], 0);
        end
        repeat (3) step;
        rst_n = 1;
        step;
        // Read 0xA123, flags 5, D_i 0x3C
        clr; d_i = 8'h3C;
        issue(0, 16'hA123, 8'h00, 4'h5);
        wait_idle;
        for (int i = 0; i < 2; i++) begin
            chk("rd_ads_cnt", i, ads_cnt[i], 1);
            chk("rd_ads_addr", i, ads_addr[i], 12'h123);
            chk("rd_ads_do", i, ads_do[i], 8'h5A);
            chk("rd_rd_cnt", i, rd_cnt[i], 1 + 2*i);
            chk("rd_latency", i, rsp_cyc[i] - acc[i], 3 + 2*i);
            chk("rd_rdata", i, rsp_val[i], 8'h3C);
        end
        // Write 0x77 to 0x0FFF
        clr;
        issue(1, 16'h0FFF, 8'h77, 4'hA);
        wait_idle;
        for (int i = 0; i < 2; i++) begin
            chk("wr_wr_cnt", i, wr_cnt[i], 1 + 2*i);
            chk("wr_data_hold", i, w77[i], 2 + 2*i);
            chk("wr_latency", i, rsp_cyc[i] - acc[i], 3 + 2*i);
        end
        // hold_n low for the first 4 strobe cycles, D_i changing every cycle
        clr;
        issue(0, 16'h1234, 8'h00, 4'h1);
        for (int k = 1; k <= 5; k++) begin
            step;
            hold_n = (k == 5);
            d_i = 8'h10 + 8'(k);
        end
        step;
        hold_n = 1;
        wait_idle;
        for (int i = 0; i < 2; i++) begin
            chk("hold_rd_cnt", i, rd_cnt[i], 5);
            chk("hold_rdata", i, rsp_val[i], 8'h15);
            chk("hold_latency", i, rsp_cyc[i] - acc[i], 7);
        end
        // bus_en gating
        bus_en = 0; req_valid = 1; req_we = 0; req_addr = 16'h0042; req_flags = 4'h2;
        repeat (10) begin
            step;
            for (int i = 0; i < 2; i++) begin
                chk("gated_ready", i, o_ready[i], 0);
                chk("gated_ads", i, o_ads[i], 1);
            end
        end
        bus_en = 1; c0 = cyc;
        #1;
        for (int i = 0; i < 2; i++) chk("en_ready", i, o_ready[i], 1);
        step;
        req_valid = 0;
        for (int i = 0; i < 2; i++) begin
            chk("en_accept_cyc", i, acc[i], c0);
            chk("en_ads", i, o_ads[i], 0);
        end
        wait_idle;
        // reset in the middle of a write strobe
        issue(1, 16'h0ABC, 8'hE5, 4'h9);
        step;
        for (int i = 0; i < 2; i++) chk("wr_before_rst", i, o_wr[i], 0);
        #1 rst_n = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_wr_n", i, o_wr[i], 1);
            chk("rst_doe_mid", i, o_doe[i], 0);
            chk("rst_busy", i, o_busy[i], 0);
        end
        step;
        rst_n = 1;
        clr;
        repeat (5) step;
        for (int i = 0; i < 2; i++) chk("no_rsp_after_rst", i, rsp_cnt[i], 0);
        d_i = 8'h99;
        issue(0, 16'h4321, 8'h00, 4'h3);
        wait_idle;
        for (int i = 0; i < 2; i++) begin
            chk("post_rst_rsp", i, rsp_cnt[i], 1);
            chk("post_rst_rdata", i, rsp_val[i], 8'h99);
            chk("post_rst_ads_do", i, ads_do[i], 8'h34);
            chk("post_rst_addr", i, ads_addr[i], 12'h321);
        end
        // back-to-back requests
        clr;
        req_valid = 1; req_we = 1; req_addr = 16'h2468; req_wdata = 8'h5C; req_flags = 4'h6;
        repeat (14) step;
        req_valid = 0;
        wait_idle;
        for (int i = 0; i < 2; i++) chk("b2b_gap", i, gap[i], 1);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step;
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(399) == 0) rst_n = 0;
            req_valid = 1'($urandom_range(1));
            req_we    = 1'($urandom_range(1));
            req_addr  = 16'($urandom);
            req_wdata = 8'($urandom);
            req_flags = 4'($urandom);
            d_i       = 8'($urandom);
            hold_n    = $urandom_range(3) != 0;
            bus_en    = $urandom_range(7) != 0;
        end
        req_valid = 0; rst_n = 1; hold_n = 1; bus_en = 1;
        wait_idle;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/scmp_bus_ctrl.md
Name: scmp_bus_ctrl

Overview:
- Parametrised external bus-cycle sequencer for the SC/MP core family.
- Replaces the fixed 12-bit address, zero-wait strobe generation inside the core.
- Accepts one read or write request at a time from the microcode sequencer and drives ADS_n, RD_n, WR_n, the address pins and a multiplexed data bus.
- Adds programmable minimum wait states, hold_n wait-state stretching, bus-enable gating and a configurable address width, with the upper address bits multiplexed onto D during the address phase.

Parameters:
- ADDR_W, 16: logical address width, in bits.
- PIN_ADDR_W, 12: number of address bits driven on the addr pins; the remaining ADDR_W-PIN_ADDR_W bits are multiplexed on D_o during ADS. Constraint: ADDR_W-PIN_ADDR_W must be at most DATA_W-4.
- DATA_W, 8: data bus width.
- MIN_WAIT, 0: minimum extra strobe cycles inserted in every access (0..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- bus_en  in  1  bus grant / enable-in; a new cycle may start only while this is 1
- hold_n  in  1  wait request, active-low, sampled during the strobe phase
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  access address
- req_wdata  in  DATA_W  write data
- req_flags  in  4  {H,D,I,R} status flags placed on D during ADS
- rsp_valid  out  1  one-cycle pulse at access completion
- rsp_rdata  out  DATA_W  read data; valid while rsp_valid=1, held until the next completion
- busy  out  1  state is not IDLE
- addr  out  PIN_ADDR_W  address pins
- D_i  in  DATA_W  data bus input
- D_o  out  DATA_W  data bus output
- D_oe  out  1  data bus output enable
- ADS_n  out  1  address strobe, active-low
- RD_n  out  1  read strobe, active-low
- WR_n  out  1  write strobe, active-low

Behaviour:
- Reset values (asynchronous, effective immediately, including mid-access):
  - State IDLE; busy=0.
  - ADS_n, RD_n and WR_n all 1; D_oe=0.
  - addr=0, D_o=0, rsp_valid=0, rsp_rdata=0, wait counter 0.
  - No partial cycle is completed and no rsp_valid is emitted after reset releases.
- req_ready = (state==IDLE) & bus_en & rst_n, combinational. A transfer occurs on a clock edge with req_valid & req_ready; at that edge the request is latched (addr, we, wdata, flags).
- State machine:
  - IDLE: all strobes high, D_oe=0. On transfer -> ADDR.
  - ADDR (exactly 1 cycle):
    - ADS_n=0; addr = latched addr[PIN_ADDR_W-1:0].
    - D_oe=1; D_o = {flags, zero padding, addr[ADDR_W-1:PIN_ADDR_W]}, with flags in the top 4 bits and the high address bits in the LSBs.
    - -> STROBE, wait counter loaded with MIN_WAIT.
  - STROBE:
    - RD_n=0 for a read, WR_n=0 for a write.
    - For a write, D_oe=1 and D_o = wdata; for a read, D_oe=0.
    - Each cycle: if counter != 0, decrement and stay. Else if hold_n==0, stay. Else -> DONE.
    - For a read, D_i is captured into rsp_rdata on that same leaving edge.
  - DONE (1 cycle):
    - Strobes high; addr held.
    - For a write, D_oe stays 1 with D_o = wdata (one-cycle data hold); D_oe=0 for a read.
    - rsp_valid=1. -> IDLE.
- addr is stable from ADDR through DONE, then holds its last value in IDLE.
- Cycle counts:
  - Accept to rsp_valid = 3 + MIN_WAIT + (number of STROBE cycles with hold_n low and counter 0).
  - Back-to-back requests are separated by exactly one IDLE cycle.
- bus_en is checked only in IDLE. Dropping bus_en mid-access does not abort the access.
- hold_n is ignored outside STROBE and while the wait counter is nonzero.
- rsp_valid and req_ready are never both 1 in the same cycle.
- ADS_n, RD_n and WR_n are mutually exclusive; at most one is low in any cycle.

Test Plan:
- Reset, then read with MIN_WAIT=0, req_addr=0xA123, flags=0x5, hold_n=1, D_i=0x3C:
  - ADS_n low for 1 cycle with addr=0x123 and D_o=0x5A.
  - RD_n low for 1 cycle.
  - rsp_valid 3 cycles after accept with rsp_rdata=0x3C.
- Write 0x77 to 0x0FFF with MIN_WAIT=2:
  - WR_n low for exactly 3 cycles with D_o=0x77, D_oe=1 through DONE.
  - rsp_valid at accept+5.
- Read with hold_n held low for 4 cycles from the first STROBE cycle:
  - RD_n low for 5 cycles.
  - rsp_rdata equals the D_i value present on the final STROBE cycle, not earlier values.
- bus_en=0 with req_valid=1 for 10 cycles:
  - req_ready=0 and ADS_n=1 throughout.
  - Raise bus_en: accept on the first edge, ADS_n low on the next cycle.
- Assert rst_n=0 mid-STROBE of a write:
  - WR_n returns to 1 and D_oe to 0 asynchronously.
  - No rsp_valid after release; the next request runs normally.
- Two queued requests, back-to-back:
  - The second accept occurs exactly one cycle after the first rsp_valid.
  - Strobes never overlap.
